// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/dispatch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_MEMRD,
        ST_LOADIR,
        ST_DECODE,
        ST_DISPATCH,
        ST_WAIT,
        ST_HALTED
    } state_t;

    // Native opcode encoding. A wider OPC_W on the controller treats any
    // opcode with bits set above this width as unmapped, except all-ones,
    // which is always HALT.
    localparam int OPC_W_DEF = 4;
    typedef logic [OPC_W_DEF-1:0] opc_t;

    localparam opc_t OPC_ALU   = 4'h0;
    localparam opc_t OPC_ALUI  = 4'h1;
    localparam opc_t OPC_MOV   = 4'h2;
    localparam opc_t OPC_MOVI  = 4'h3;
    localparam opc_t OPC_STORE = 4'h4;
    localparam opc_t OPC_LOAD  = 4'h5;
    localparam opc_t OPC_HALT  = 4'hF;

    // Execution channel index; CH_NONE marks an opcode with no channel.
    typedef logic [2:0] ch_t;
    localparam ch_t CH_ALU   = 3'd0;
    localparam ch_t CH_ALUI  = 3'd1;
    localparam ch_t CH_MOV   = 3'd2;
    localparam ch_t CH_MOVI  = 3'd3;
    localparam ch_t CH_STORE = 3'd4;
    localparam ch_t CH_LOAD  = 3'd5;
    localparam ch_t CH_NONE  = 3'd7;

    function automatic ch_t opc2ch(input opc_t opc);
        ch_t ch;
        ch = CH_NONE;
        case (opc)
            OPC_ALU:   ch = CH_ALU;
            OPC_ALUI:  ch = CH_ALUI;
            OPC_MOV:   ch = CH_MOV;
            OPC_MOVI:  ch = CH_MOVI;
            OPC_STORE: ch = CH_STORE;
            OPC_LOAD:  ch = CH_LOAD;
            default:   ch = CH_NONE;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/tmo_counter.sv
// Per-state watchdog: counts cycles spent in a guarded state.
// Latency: expired is combinational on the (2^TMO_W-1)-th enabled cycle.
// Backpressure: none; clear has priority over enable.
// Ports: clock/reset, clear (state entry), enable (in guarded state), expired.
module tmo_counter #(
    parameter int TMO_W = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // cnt_q holds the number of guarded cycles already completed, so the
    // cycle in which cnt_q == 2^TMO_W-2 is the last one allowed.
    localparam logic [TMO_W-1:0] LAST = TMO_W'((1 << TMO_W) - 2);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/fetch_dispatch_unit.sv
// Fetch/decode sequencer that hands each instruction to one execution channel.
// Latency: ADDR 1 + MEMRD until MFC + LOADIR 1 + DECODE 1 + DISPATCH 1 + WAIT until done.
// Backpressure: holds in MEMRD/WAIT until MFC/done; gives up after 2^TMO_W-1 cycles.
// Ports: start/run_mode/stop control, opcode + MFC + fsm_done status in;
//        bus/memory enables, one-hot fsm_start, busy/halted, sticky errors,
//        retired-instruction count out. All outputs are registered.
module fetch_dispatch_unit
    import cpu_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int OPC_W  = 4,
    parameter int TMO_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              run_mode,
    input  logic              stop,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              MFC,
    input  logic [NUM_CH-1:0] fsm_done,
    output logic              EN,
    output logic              R_W,
    output logic              pc_out_en,
    output logic              pc_increment_en,
    output logic              MAR_address_in_en,
    output logic              MDR_bus_data_out_en,
    output logic              IR_in_en,
    output logic [NUM_CH-1:0] fsm_start,
    output logic              busy,
    output logic              halted,
    output logic              err_illegal,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  instr_count
);

    state_t            state_q, state_d, after_retire;
    ch_t               ch_dec;
    logic [31:0]       opc_ext;
    logic [NUM_CH-1:0] dec_sel, sel_q;
    logic              is_halt, is_mapped, done_hit;
    logic              stop_q, stop_seen, busy_now;
    logic              start_acc, retire, illegal, tmo_fire;
    logic              tmo_clear, tmo_en, tmo_expired;

    // ---------------- opcode decode ----------------
    assign opc_ext = 32'(opcode);
    assign is_halt = (opcode == {OPC_W{1'b1}});

    always_comb begin
        ch_dec = CH_NONE;
        if (opc_ext[31:OPC_W_DEF] == '0) begin
            ch_dec = opc2ch(opc_ext[OPC_W_DEF-1:0]);
        end
        dec_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((ch_dec != CH_NONE) && (int'(ch_dec) == i)) begin
                dec_sel[i] = 1'b1;
            end
        end
    end

    assign is_mapped = |dec_sel;
    // Only the dispatched channel can retire the instruction.
    assign done_hit  = |(fsm_done & sel_q);

    // ---------------- stop latch ----------------
    assign busy_now  = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    // A stop raised in the retiring cycle itself must also end the run.
    assign stop_seen = stop_q | (stop & busy_now);
    assign after_retire = (run_mode && !stop_seen) ? ST_ADDR : ST_IDLE;

    // ---------------- next state ----------------
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        tmo_fire  = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d   = ST_ADDR;
                    start_acc = 1'b1;
                end
            end
            ST_ADDR:   state_d = ST_MEMRD;
            ST_MEMRD: begin
                if (MFC) begin
                    state_d = ST_LOADIR;
                end else if (tmo_expired) begin
                    state_d  = ST_IDLE;
                    tmo_fire = 1'b1;
                end
            end
            ST_LOADIR: state_d = ST_DECODE;
            ST_DECODE: begin
                if (is_halt) begin
                    state_d = ST_HALTED;
                    retire  = 1'b1;
                end else if (is_mapped) begin
                    state_d = ST_DISPATCH;
                end else begin
                    // Unmapped opcode: flag it and retire without executing.
                    illegal = 1'b1;
                    retire  = 1'b1;
                    state_d = after_retire;
                end
            end
            ST_DISPATCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (done_hit) begin
                    retire  = 1'b1;
                    state_d = after_retire;
                end else if (tmo_expired) begin
                    state_d  = ST_IDLE;
                    tmo_fire = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- watchdog ----------------
    assign tmo_clear = (state_d != state_q);
    assign tmo_en    = (state_q == ST_MEMRD) || (state_q == ST_WAIT);

    tmo_counter #(
        .TMO_W   (TMO_W)
    ) u_tmo (
        .clock   (clock),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    // ---------------- state and bookkeeping ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            stop_q      <= 1'b0;
            instr_count <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                sel_q <= dec_sel;
            end
            if (state_d == ST_IDLE) begin
                stop_q <= 1'b0;
            end else if (stop && busy_now) begin
                stop_q <= 1'b1;
            end
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
            if (start_acc) begin
                err_illegal <= 1'b0;
                err_timeout <= 1'b0;
            end else begin
                if (illegal)  err_illegal <= 1'b1;
                if (tmo_fire) err_timeout <= 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state and registered, so each one
    // lines up exactly with the state it belongs to and never glitches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            EN                  <= 1'b0;
            R_W                 <= 1'b0;
            pc_out_en           <= 1'b0;
            pc_increment_en     <= 1'b0;
            MAR_address_in_en   <= 1'b0;
            MDR_bus_data_out_en <= 1'b0;
            IR_in_en            <= 1'b0;
            fsm_start           <= '0;
            busy                <= 1'b0;
            halted              <= 1'b0;
        end else begin
            EN                  <= (state_d == ST_MEMRD);
            R_W                 <= (state_d == ST_MEMRD);
            pc_out_en           <= (state_d == ST_ADDR);
            MAR_address_in_en   <= (state_d == ST_ADDR);
            pc_increment_en     <= (state_d == ST_LOADIR);
            MDR_bus_data_out_en <= (state_d == ST_LOADIR);
            IR_in_en            <= (state_d == ST_LOADIR);
            // DISPATCH is only entered from DECODE, where dec_sel is live.
            fsm_start           <= (state_d == ST_DISPATCH) ? dec_sel : '0;
            busy                <= (state_d != ST_IDLE) && (state_d != ST_HALTED);
            halted              <= (state_d == ST_HALTED);
        end
    end

endmodule
